// File: rtl/round_robin_encoder_4.sv
// Four-channel round-robin arbiter driving a 2-4 decoder with a registered channel index.
// Optional hold-time limit with forced release is enabled by defining ARB_TIMEOUT_EN.
module round_robin_encoder_4 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic [3:0] Request_In,
    input  logic       Release_In,
    output logic       Grant_Valid_Out,
    output logic [1:0] Encoded_Value_Out,
    output logic       Decoder_Reset_Out,
    output logic       Timeout_Out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [1:0] ptr_r, ptr_s;
    logic [1:0] enc_r, enc_s;
    logic       grant_valid_r, grant_valid_s;
    logic       timeout_r, timeout_s;
    logic [2:0] win_s;
    logic       normal_end_s;
    logic       limit_s;
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_r, cnt_s;
`endif

    // HOLD_MAX must fit the 8-bit saturating hold counter
    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_check
        $error("HOLD_MAX out of range 2..255");
    end

    // Returns {found, index} of the first requesting channel at or after ptr, wrapping D->A
    function automatic logic [2:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state, pointer, index and pulse logic
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        enc_s         = enc_r;
        grant_valid_s = 1'b0;
        timeout_s     = 1'b0;
        win_s         = pick_winner(Request_In, ptr_r);
        normal_end_s  = Release_In | ~Request_In[enc_r];
`ifdef ARB_TIMEOUT_EN
        cnt_s         = cnt_r;
        limit_s       = (cnt_r == 8'(HOLD_MAX));
`else
        limit_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (win_s[2]) begin
                    state_s       = ST_GRANT;
                    enc_s         = win_s[1:0];
                    grant_valid_s = 1'b1;
                    ptr_s         = win_s[1:0] + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    cnt_s         = 8'd1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (normal_end_s) begin
                    state_s = ST_GAP;
                end else if (limit_s) begin
                    // Forced release only reports a timeout when no normal release coincides
                    state_s   = ST_GAP;
                    timeout_s = 1'b1;
                end else begin
                    state_s       = ST_GRANT;
                    grant_valid_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    if (cnt_r != 8'hFF) begin
                        cnt_s = cnt_r + 8'd1;
                    end else begin
                        cnt_s = cnt_r;
                    end
`endif
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 2'd0;
            enc_r         <= 2'b00;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_r         <= 8'd0;
`endif
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            enc_r         <= enc_s;
            grant_valid_r <= grant_valid_s;
            timeout_r     <= timeout_s;
`ifdef ARB_TIMEOUT_EN
            cnt_r         <= cnt_s;
`endif
        end
    end

    assign Grant_Valid_Out   = grant_valid_r;
    assign Encoded_Value_Out = enc_r;
    assign Decoder_Reset_Out = ~grant_valid_r;
    assign Timeout_Out       = timeout_r;

endmodule

// File: tb/tb_round_robin_encoder_4.sv
// Scoreboard bench for round_robin_encoder_4: directed scenarios plus random traffic
// checked against a behavioural owner/pointer model.
module tb_round_robin_encoder_4;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic       gv;
    logic [1:0] enc;
    logic       drst;
    logic       tmo;

    round_robin_encoder_4 #(.HOLD_MAX(HOLD)) dut (
        .Clock_In          (clk),
        .Reset_In          (rst),
        .Request_In        (req),
        .Release_In        (rel),
        .Grant_Valid_Out   (gv),
        .Encoded_Value_Out (enc),
        .Decoder_Reset_Out (drst),
        .Timeout_Out       (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected {grant_valid, index[1:0], decoder_reset, timeout}
    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // behavioural model
    int  owner = -1;
    bit  in_gap = 1'b0;
    int  ptr = 0;
    int  held = 0;
    int  last = 0;
    bit  m_to = 1'b0;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    task automatic model_edge(input logic [3:0] r, input logic rl, input logic rs);
        bit normal;
        if (rs) begin
            owner = -1; in_gap = 1'b0; ptr = 0; held = 0; last = 0; m_to = 1'b0;
        end else if (in_gap) begin
            in_gap = 1'b0; m_to = 1'b0;
        end else if (owner >= 0) begin
            normal = rl || !r[owner];
            if (normal || (TO_EN && held == HOLD)) begin
                m_to = !normal;
                in_gap = 1'b1;
                owner = -1;
            end else begin
                held = (held < 255) ? held + 1 : 255;
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (owner < 0 && r[(ptr + k) % 4]) begin
                    owner = (ptr + k) % 4;
                end
            end
            if (owner >= 0) begin
                last = owner;
                held = 1;
                ptr = (owner + 1) % 4;
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rl, input logic rs);
        logic g;
        @(negedge clk);
        req = r; rel = rl; rst = rs;
        @(posedge clk);
        model_edge(r, rl, rs);
        g = (owner >= 0);
        exp_q.push_back({g, 2'(last), ~g, m_to});
    endtask

    // monitor: compares one expected tuple per cycle, away from the active edge
    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({gv, enc, drst, tmo} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got gv=%b enc=%b drst=%b to=%b want gv=%b enc=%b drst=%b to=%b",
                         $time, gv, enc, drst, tmo, e[4], e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        req = 4'b0000; rel = 1'b0; rst = 1'b1;
        // reset then idle
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        repeat (5) step(4'b0000, 1'b0, 1'b0);
        // rotation with release two cycles after each grant
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b1, 1'b0);
            step(4'b1111, 1'b0, 1'b0);
        end
        // pointer wrap and skip: grant C, then A, then B
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        // request drop on owner B
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        // timeout: hold A with no release
        repeat (12) step(4'b0001, 1'b0, 1'b0);
        // limit coinciding with release is a normal release
        step(4'b0000, 1'b0, 1'b0);
        repeat (4) step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        // reset mid-grant on D, then first grant is A
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 59) == 0));
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin_encoder_4.md
# round_robin_encoder_4

Four-channel round-robin arbiter whose output is a registered 2-bit channel index. The index drives the 2-4 decoder's `Encoded_Value_In`, and the decoder's `Reset_In` is driven from `Decoder_Reset_Out`, so the decoder raises exactly one one-hot select line for the channel that owns the shared resource. Grants are held until release, with a one-cycle break-before-make gap between owners and an optional hold-time limit.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant may stay valid; legal range 2..255. Used only with `ARB_TIMEOUT_EN`.
- `Clock_In` in 1: sole clock; all state changes on its rising edge.
- `Reset_In` in 1: reset, synchronous and active-high.
- `Request_In` in 4: per-channel request levels. Bit 0 = A (code 00), bit 1 = B (01), bit 2 = C (10), bit 3 = D (11).
- `Release_In` in 1: current owner finished; sampled only in GRANT.
- `Grant_Valid_Out` out 1: a grant is active; registered.
- `Encoded_Value_Out` out 2: granted channel index; registered; feeds decoder `Encoded_Value_In`.
- `Decoder_Reset_Out` out 1: equals `~Grant_Valid_Out`; drives decoder `Reset_In`, forcing all decoder outputs to 0 when there is no grant.
- `Timeout_Out` out 1: one-cycle pulse after a forced release.

## Operation
- States: IDLE, GRANT, GAP. 2-bit priority pointer `Ptr` = first index searched.
- Reset values:
  - state IDLE, `Ptr` = 0;
  - hold counter = 0 (8 bits);
  - `Grant_Valid_Out` = 0, `Encoded_Value_Out` = 2'b00, `Decoder_Reset_Out` = 1, `Timeout_Out` = 0.
- IDLE, `Request_In` == 0: stay in IDLE.
- IDLE, any request set:
  - winner = first set bit searching `Ptr`, `Ptr`+1, ... modulo 4 (wraps D->A);
  - next state GRANT; `Encoded_Value_Out` = winner; `Grant_Valid_Out` = 1;
  - counter = 1; `Ptr` = winner+1 mod 4.
- GRANT ends, and the next state is GAP, when any of these holds:
  - `Release_In` = 1;
  - the owner's request bit is 0;
  - (macro on) counter == `HOLD_MAX`.
- GRANT otherwise: stay in GRANT; counter increments and saturates at 255.
- GAP: lasts exactly one cycle.
  - `Grant_Valid_Out` = 0.
  - `Encoded_Value_Out` holds the last index.
  - Next state is always IDLE.
  - Requests are not sampled in GAP.
- Entering GAP through a forced limit sets `Timeout_Out` = 1 for that one GAP cycle.
- If a normal release condition and the limit coincide, the release is normal and `Timeout_Out` stays 0.
- `Release_In` is ignored in IDLE and GAP.
- A request change on a non-owner channel during GRANT has no effect.
- `Encoded_Value_Out` changes only on entry to GRANT, so the decoder input never glitches while a grant is valid.

## Timing
- Request sampled in IDLE at edge N -> `Grant_Valid_Out`/`Encoded_Value_Out` valid after edge N (1-cycle latency).
- Release sampled at edge M -> `Grant_Valid_Out` low after edge M, GAP for one cycle, IDLE after M+1. Earliest next grant is after edge M+2.
- Owner-to-owner minimum turnaround: 2 cycles with grant low; 1 cycle of that is guaranteed-low GAP.
- Forced limit: `Grant_Valid_Out` is high for exactly `HOLD_MAX` cycles. `Timeout_Out` is high in the following cycle.
- `Reset_In` high at any edge, including mid-GRANT: all state and outputs take reset values after that edge. Requests are ignored while reset is high.
- `Decoder_Reset_Out` is combinational from the `Grant_Valid_Out` register only; it has no path from inputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - the hold counter compares against `HOLD_MAX`;
  - forced release and `Timeout_Out` pulses are active.
- `ARB_TIMEOUT_EN` undefined:
  - no limit; grants end only on release or request drop;
  - `Timeout_Out` is tied to 0;
  - the counter and comparator logic is removed; `HOLD_MAX` is unused.

## Test plan
- Reset then idle: `Reset_In` = 1 for 2 cycles, then `Request_In` = 0 for 5 cycles -> `Grant_Valid_Out` = 0, `Encoded_Value_Out` = 00, `Decoder_Reset_Out` = 1 throughout.
- Rotation: `Request_In` = 4'b1111 constant, `Release_In` pulsed 2 cycles after each grant -> grant order 00, 01, 10, 11, 00, with exactly one GAP cycle (`Grant_Valid_Out` = 0) before each new grant.
- Pointer wrap and skip: grant C (10), release, then `Request_In` = 4'b0011 -> next grant is A (00), then B (01).
- Request drop: grant B, deassert `Request_In[1]` with no release -> `Grant_Valid_Out` low on the next edge and `Timeout_Out` stays 0.
- Timeout (macro on, `HOLD_MAX` = 4): hold `Request_In` = 4'b0001 with no release -> 4 valid cycles, GAP cycle with `Timeout_Out` = 1, then re-grant 00 two cycles after the drop.
- Reset mid-grant: assert `Reset_In` while granting D -> all outputs at reset values after the edge; first grant after reset with `Request_In` = 4'b1111 is A (00).
